controle_multiciclo: RTL and testbench

//  Multicycle MIPS control FSM; sequences the shared datapath (single ALU, unified memory, IR, PC)
//  one instruction at a time, replacing the single-cycle combinational control decode.

---
 rtl/controle_multiciclo.sv | 215 +++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: sequences one shared ALU, unified memory,
// IR and PC through FETCH/DECODE/execute states, one instruction at a time.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   opCode          IR[31:26], looked at in DECODE and MEMADR only
//   mem_ready       memory finishes the current access this cycle
//   mem_req/IorD/MemWrite/IRWrite/PCWrite/Branch/PCSrc   memory and PC control
//   ALUSrcA/ALUSrcB/ALUOp                                ALU operand and op select
//   RegDst/MemtoReg/RegWrite                             register write-back
//   illegal_op      one-cycle pulse when DECODE sees an unknown opcode
//   state           current state code (debug)
//   instr_cnt       retired-instruction counter, wraps
module controle_multiciclo #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opCode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;

  logic       w_mem_req;
  logic       w_iord;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_pcwrite;
  logic       w_branch;
  logic [1:0] w_pcsrc;
  logic       w_srca;
  logic [1:0] w_srcb;
  logic [1:0] w_aluop;
  logic       w_regdst;
  logic       w_memtoreg;
  logic       w_regwrite;
  logic       w_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_mem_req  = 1'b0;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_pcsrc    = 2'b00;
    w_srca     = 1'b0;
    w_srcb     = 2'b00;
    w_aluop    = 2'b00;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_srcb    = 2'b01;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        w_srcb = 2'b11;
        case (opCode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_next = (opCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (mem_ready)
          w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req  = 1'b1;
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXECUTE: begin
        w_srca  = 1'b1;
        w_aluop = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        w_srca   = 1'b1;
        w_aluop  = 2'b01;
        w_branch = 1'b1;
        w_pcsrc  = 2'b01;
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_ADDIEX: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks every strobe so an aborted instruction leaves no side effect.
  assign mem_req    = w_mem_req  & ~reset;
  assign IorD       = w_iord     & ~reset;
  assign MemWrite   = w_memwrite & ~reset;
  assign IRWrite    = w_irwrite  & ~reset;
  assign PCWrite    = w_pcwrite  & ~reset;
  assign Branch     = w_branch   & ~reset;
  assign PCSrc      = reset ? 2'b00 : w_pcsrc;
  assign ALUSrcA    = w_srca     & ~reset;
  assign ALUSrcB    = reset ? 2'b00 : w_srcb;
  assign ALUOp      = reset ? 2'b00 : w_aluop;
  assign RegDst     = w_regdst   & ~reset;
  assign MemtoReg   = w_memtoreg & ~reset;
  assign RegWrite   = w_regwrite & ~reset;
  assign illegal_op = w_illegal  & ~reset;
  assign state      = r_state;
  assign instr_cnt  = r_cnt;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: per-cycle state/control checks
// for each instruction class, wait states, illegal opcode, reset, wrap.
module tb_controle_multiciclo;

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000;
  localparam logic [5:0] JP = 6'b000010;
  localparam logic [5:0] XX = 6'b111111;

  // {mem_req,IorD,MemWrite,IRWrite,PCWrite,Branch}_PCSrc_ALUSrcA
  // _ALUSrcB_ALUOp_{RegDst,MemtoReg,RegWrite,illegal_op}
  localparam logic [16:0] E_ZERO   = 17'b000000_00_0_00_00_0000;
  localparam logic [16:0] E_FETCHR = 17'b100110_00_0_01_00_0000;
  localparam logic [16:0] E_FETCHW = 17'b100000_00_0_01_00_0000;
  localparam logic [16:0] E_DEC    = 17'b000000_00_0_11_00_0000;
  localparam logic [16:0] E_DECILL = 17'b000000_00_0_11_00_0001;
  localparam logic [16:0] E_MEMADR = 17'b000000_00_1_10_00_0000;
  localparam logic [16:0] E_MEMRD  = 17'b110000_00_0_00_00_0000;
  localparam logic [16:0] E_MEMWB  = 17'b000000_00_0_00_00_0110;
  localparam logic [16:0] E_MEMWR  = 17'b111000_00_0_00_00_0000;
  localparam logic [16:0] E_EXE    = 17'b000000_00_1_00_10_0000;
  localparam logic [16:0] E_ALUWB  = 17'b000000_00_0_00_00_1010;
  localparam logic [16:0] E_BR     = 17'b000001_01_1_00_01_0000;
  localparam logic [16:0] E_ADDIEX = 17'b000000_00_1_10_00_0000;
  localparam logic [16:0] E_ADDIWB = 17'b000000_00_0_00_00_0010;
  localparam logic [16:0] E_JUMP   = 17'b000010_10_0_00_00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opCode;
  logic        mem_ready;

  logic        mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch;
  logic [1:0]  PCSrc, ALUSrcB, ALUOp;
  logic        ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  logic        d4_mem_req, d4_IorD, d4_MemWrite, d4_IRWrite, d4_PCWrite;
  logic        d4_Branch, d4_ALUSrcA, d4_RegDst, d4_MemtoReg, d4_RegWrite;
  logic        d4_illegal_op;
  logic [1:0]  d4_PCSrc, d4_ALUSrcB, d4_ALUOp;
  logic [3:0]  d4_state;
  logic [3:0]  d4_instr_cnt;

  wire [16:0] ctl = {mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch,
                     PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                     RegDst, MemtoReg, RegWrite, illegal_op};

  controle_multiciclo u_dut (
    .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal_op(illegal_op), .state(state), .instr_cnt(instr_cnt)
  );

  controle_multiciclo #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
    .mem_req(d4_mem_req), .IorD(d4_IorD), .MemWrite(d4_MemWrite),
    .IRWrite(d4_IRWrite), .PCWrite(d4_PCWrite), .Branch(d4_Branch),
    .PCSrc(d4_PCSrc), .ALUSrcA(d4_ALUSrcA), .ALUSrcB(d4_ALUSrcB),
    .ALUOp(d4_ALUOp), .RegDst(d4_RegDst), .MemtoReg(d4_MemtoReg),
    .RegWrite(d4_RegWrite), .illegal_op(d4_illegal_op),
    .state(d4_state), .instr_cnt(d4_instr_cnt)
  );

  always #5 clk = ~clk;

  int          vecs = 0;
  int          miss = 0;
  logic [31:0] exp_cnt;

  int          v_n;
  logic        v_rs [16];
  logic        v_rd [16];
  logic [5:0]  v_op [16];
  logic [3:0]  v_es [16];
  logic [16:0] v_ec [16];
  logic [3:0]  o_st [16];
  logic [16:0] o_ctl[16];

  task automatic push(input logic rs, input logic rd, input logic [5:0] op,
                      input logic [3:0] es, input logic [16:0] ec);
    v_rs[v_n] = rs;
    v_rd[v_n] = rd;
    v_op[v_n] = op;
    v_es[v_n] = es;
    v_ec[v_n] = ec;
    v_n++;
  endtask

  // Drives one vector per cycle and records what the DUT shows mid-cycle.
  task automatic apply();
    for (int i = 0; i < v_n; i++) begin
      reset     = v_rs[i];
      mem_ready = v_rd[i];
      opCode    = v_op[i];
      #1;
      o_st[i]  = state;
      o_ctl[i] = ctl;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (ctl !== E_ZERO || state !== 4'd0 || instr_cnt !== 32'd0) begin
        miss++;
        $display("FAIL reset cyc%0d: ctl=%b st=%0d cnt=%0d, want 0",
                 i, ctl, state, instr_cnt);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    vecs++;
    if (state !== 4'd0 || instr_cnt !== 32'd0 || d4_instr_cnt !== 4'd0) begin
      miss++;
      $display("FAIL reset_rel: st=%0d cnt=%0d cnt4=%0d, want 0",
               state, instr_cnt, d4_instr_cnt);
    end
  endtask

  task automatic test_rtype();
    v_n = 0;
    push(0, 1, RT, 0, E_FETCHR);
    push(0, 1, RT, 1, E_DEC);
    push(0, 1, RT, 6, E_EXE);
    push(0, 1, RT, 7, E_ALUWB);
    apply();
    for (int i = 0; i < v_n; i++) begin
      vecs++;
      if (o_st[i] !== v_es[i] || o_ctl[i] !== v_ec[i]) begin
        miss++;
        $display("FAIL rtype cyc%0d: st=%0d ctl=%b, want st=%0d ctl=%b",
                 i, o_st[i], o_ctl[i], v_es[i], v_ec[i]);
      end
    end
    exp_cnt = exp_cnt + 1;
    vecs++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      miss++;
      $display("FAIL rtype_end: st=%0d cnt=%0d, want st=0 cnt=%0d",
               state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_lw_wait();
    int irw;
    v_n = 0;
    push(0, 0, XX, 0, E_FETCHW);
    push(0, 0, XX, 0, E_FETCHW);
    push(0, 1, XX, 0, E_FETCHR);
    push(0, 1, LW, 1, E_DEC);
    push(0, 1, LW, 2, E_MEMADR);
    push(0, 0, XX, 3, E_MEMRD);
    push(0, 0, XX, 3, E_MEMRD);
    push(0, 1, XX, 3, E_MEMRD);
    push(0, 1, XX, 4, E_MEMWB);
    apply();
    irw = 0;
    for (int i = 0; i < v_n; i++) begin
      irw += int'(o_ctl[i][13]);
      vecs++;
      if (o_st[i] !== v_es[i] || o_ctl[i] !== v_ec[i]) begin
        miss++;
        $display("FAIL lw cyc%0d: st=%0d ctl=%b, want st=%0d ctl=%b",
                 i, o_st[i], o_ctl[i], v_es[i], v_ec[i]);
      end
    end
    vecs++;
    if (irw != 1) begin
      miss++;
      $display("FAIL lw_irwrite: pulses=%0d, want 1", irw);
    end
    exp_cnt = exp_cnt + 1;
    vecs++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      miss++;
      $display("FAIL lw_end: st=%0d cnt=%0d, want st=0 cnt=%0d",
               state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_sw_wait();
    v_n = 0;
    push(0, 1, SW, 0, E_FETCHR);
    push(0, 1, SW, 1, E_DEC);
    push(0, 1, SW, 2, E_MEMADR);
    push(0, 0, SW, 5, E_MEMWR);
    push(0, 0, SW, 5, E_MEMWR);
    push(0, 1, SW, 5, E_MEMWR);
    apply();
    for (int i = 0; i < v_n; i++) begin
      vecs++;
      if (o_st[i] !== v_es[i] || o_ctl[i] !== v_ec[i]) begin
        miss++;
        $display("FAIL sw cyc%0d: st=%0d ctl=%b, want st=%0d ctl=%b",
                 i, o_st[i], o_ctl[i], v_es[i], v_ec[i]);
      end
    end
    exp_cnt = exp_cnt + 1;
    vecs++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      miss++;
      $display("FAIL sw_end: st=%0d cnt=%0d, want st=0 cnt=%0d",
               state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_beq_addi_j();
    v_n = 0;
    push(0, 1, BQ, 0, E_FETCHR);
    push(0, 1, BQ, 1, E_DEC);
    push(0, 1, BQ, 8, E_BR);
    push(0, 1, AI, 0, E_FETCHR);
    push(0, 1, AI, 1, E_DEC);
    push(0, 1, AI, 9, E_ADDIEX);
    push(0, 1, AI, 10, E_ADDIWB);
    push(0, 1, JP, 0, E_FETCHR);
    push(0, 1, JP, 1, E_DEC);
    push(0, 1, JP, 11, E_JUMP);
    apply();
    for (int i = 0; i < v_n; i++) begin
      vecs++;
      if (o_st[i] !== v_es[i] || o_ctl[i] !== v_ec[i]) begin
        miss++;
        $display("FAIL b2b cyc%0d: st=%0d ctl=%b, want st=%0d ctl=%b",
                 i, o_st[i], o_ctl[i], v_es[i], v_ec[i]);
      end
    end
    exp_cnt = exp_cnt + 3;
    vecs++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      miss++;
      $display("FAIL b2b_end: st=%0d cnt=%0d, want st=0 cnt=%0d",
               state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_illegal();
    v_n = 0;
    push(0, 1, XX, 0, E_FETCHR);
    push(0, 1, XX, 1, E_DECILL);
    push(0, 1, 6'b000011, 0, E_FETCHR);
    push(0, 1, 6'b000011, 1, E_DECILL);
    apply();
    for (int i = 0; i < v_n; i++) begin
      vecs++;
      if (o_st[i] !== v_es[i] || o_ctl[i] !== v_ec[i]) begin
        miss++;
        $display("FAIL illegal cyc%0d: st=%0d ctl=%b, want st=%0d ctl=%b",
                 i, o_st[i], o_ctl[i], v_es[i], v_ec[i]);
      end
    end
    vecs++;
    if (state !== 4'd0 || instr_cnt !== exp_cnt) begin
      miss++;
      $display("FAIL illegal_end: st=%0d cnt=%0d, want st=0 cnt=%0d",
               state, instr_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    v_n = 0;
    push(0, 1, LW, 0, E_FETCHR);
    push(0, 1, LW, 1, E_DEC);
    push(0, 1, LW, 2, E_MEMADR);
    push(1, 1, LW, 3, E_ZERO);
    push(0, 0, LW, 0, E_FETCHW);
    apply();
    for (int i = 0; i < v_n; i++) begin
      vecs++;
      if (o_st[i] !== v_es[i] || o_ctl[i] !== v_ec[i]) begin
        miss++;
        $display("FAIL rstmid cyc%0d: st=%0d ctl=%b, want st=%0d ctl=%b",
                 i, o_st[i], o_ctl[i], v_es[i], v_ec[i]);
      end
    end
    exp_cnt = 32'd0;
    vecs++;
    if (state !== 4'd0 || instr_cnt !== 32'd0 || d4_instr_cnt !== 4'd0) begin
      miss++;
      $display("FAIL rstmid_end: st=%0d cnt=%0d cnt4=%0d, want 0",
               state, instr_cnt, d4_instr_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp4;
    for (int k = 0; k < 16; k++) begin
      v_n = 0;
      push(0, 1, JP, 0, E_FETCHR);
      push(0, 1, JP, 1, E_DEC);
      push(0, 1, JP, 11, E_JUMP);
      apply();
      for (int i = 0; i < v_n; i++) begin
        vecs++;
        if (o_st[i] !== v_es[i] || o_ctl[i] !== v_ec[i]) begin
          miss++;
          $display("FAIL wrap j%0d cyc%0d: st=%0d ctl=%b, want %0d %b",
                   k, i, o_st[i], o_ctl[i], v_es[i], v_ec[i]);
        end
      end
      exp_cnt = exp_cnt + 1;
      exp4    = exp_cnt[3:0];
      vecs++;
      if (instr_cnt !== exp_cnt || d4_instr_cnt !== exp4) begin
        miss++;
        $display("FAIL wrap_cnt j%0d: cnt=%0d cnt4=%0d, want %0d %0d",
                 k, instr_cnt, d4_instr_cnt, exp_cnt, exp4);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opCode    = RT;
    exp_cnt   = 32'd0;
    v_n       = 0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_beq_addi_j();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
